// File: rtl/conv1d_fetch_pkg.sv
// Shared definitions for the conv1d input fetch stage:
// FSM state encoding and OBI read constants.
package conv1d_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FLUSH = 2'd3
  } fetch_state_e;

  localparam logic [3:0]  OBI_BE_FULL = 4'hF;
  localparam logic [31:0] WORD_BYTES  = 32'd4;

endpackage

// File: rtl/conv1d_obi_pkg.sv
// OBI bus types shared by the conv1d blocks.
//   obi_req_t  : master -> slave request (req, we, be, addr, wdata)
//   obi_resp_t : slave -> master response (gnt, rvalid, rdata)
package conv1d_obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/conv1d_fetch_fifo.sv
// Show-ahead synchronous FIFO used to buffer fetched words.
//   clk_i/rst_ni : clock, async active-low reset
//   push_i/wdata_i : write strobe and data
//   pop_i        : consume the head entry
//   flush_i      : empty the FIFO (wins over push/pop)
//   rdata_o      : head entry (valid when !empty_o)
//   empty_o/full_o/count_o : occupancy status
// Pointers carry an extra MSB so full and empty are distinguishable.
module conv1d_fetch_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         wdata_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [Width-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] PtrOne = (AW+1)'(1);

  logic [Width-1:0] mem_q [Depth];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/conv1d_fetch.sv
// conv1d input fetch stage: reads len_i words starting at src_addr_i over
// OBI, buffers them and streams them to the conv1d core.
//   clk_i, rst_ni             : clock, async active-low reset
//   start_i, clear_i          : start pulse (IDLE only), abort/flush
//   src_addr_i, len_i         : block base byte address and word count
//   obi_req_o, obi_rsp_i      : OBI read master
//   data_o, valid_o, ready_i, last_o : output stream
//   busy_o, done_o            : status, one-cycle completion pulse
module conv1d_fetch
  import conv1d_fetch_pkg::*;
  import conv1d_obi_pkg::*;
#(
  parameter int unsigned Depth    = 4,
  parameter int unsigned LenWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                clear_i,
  input  logic [31:0]         src_addr_i,
  input  logic [LenWidth-1:0] len_i,
  output obi_req_t            obi_req_o,
  input  obi_resp_t           obi_rsp_i,
  output logic [31:0]         data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                last_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int unsigned       CW     = $clog2(Depth) + 1;
  localparam logic [CW:0]       DepthC = (CW+1)'(Depth);
  localparam logic [LenWidth-1:0] LenOne = LenWidth'(1);

  fetch_state_e        state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [LenWidth-1:0] len_q, len_d, issued_q, issued_d, deliv_q, deliv_d;
  logic [CW-1:0]       outst_q, outst_d;
  logic                done_q, done_d;

  logic [CW-1:0] fifo_cnt;
  logic [31:0]   fifo_data, src_aligned;
  logic          fifo_empty, fifo_full;
  logic          active, clr, credit_ok, req, gnt_hs, rsp_hs, push, pop, final_pop;

  assign src_aligned = src_addr_i & ~32'h3;
  assign active      = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign clr         = clear_i && active;

  // Buffered plus in-flight words never exceed Depth, so every response has a slot.
  assign credit_ok = ({1'b0, fifo_cnt} + {1'b0, outst_q}) < DepthC;
  assign req       = (state_q == ST_FETCH) && !clear_i && (issued_q < len_q) && credit_ok;
  assign gnt_hs    = req && obi_rsp_i.gnt;
  // Responses with nothing outstanding (e.g. in flight across a reset) are dropped.
  assign rsp_hs    = obi_rsp_i.rvalid && (outst_q != '0);
  assign push      = rsp_hs && active && !clear_i;

  assign valid_o   = !fifo_empty && !clr;
  assign pop       = valid_o && ready_i;
  assign final_pop = pop && (deliv_q == len_q - LenOne);
  assign last_o    = valid_o && (deliv_q == len_q - LenOne);
  assign data_o    = fifo_data;
  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = done_q;

  always_comb begin
    obi_req_o      = '0;
    obi_req_o.req  = req;
    obi_req_o.addr = addr_q;
    obi_req_o.be   = OBI_BE_FULL;
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    issued_d = issued_q;
    deliv_d  = deliv_q;
    done_d   = 1'b0;
    outst_d  = outst_q + CW'(gnt_hs) - CW'(rsp_hs);
    if (gnt_hs) begin
      addr_d   = addr_q + WORD_BYTES;
      issued_d = issued_q + LenOne;
    end
    if (pop) deliv_d = deliv_q + LenOne;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            state_d  = ST_FETCH;
            addr_d   = src_aligned;
            len_d    = len_i;
            issued_d = '0;
            deliv_d  = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        if (clear_i)                 state_d = ST_FLUSH;
        else if (issued_q == len_q)  state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (clear_i) begin
          state_d = ST_FLUSH;
        end else if (final_pop) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (outst_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      deliv_q  <= '0;
      outst_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      deliv_q  <= deliv_d;
      outst_q  <= outst_d;
      done_q   <= done_d;
    end
  end

  conv1d_fetch_fifo #(
    .Depth (Depth),
    .Width (32)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (obi_rsp_i.rdata),
    .pop_i   (pop),
    .flush_i (clr),
    .rdata_o (fifo_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_cnt)
  );

  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && fifo_full && !pop));

endmodule

// File: tb/tb_conv1d_fetch.sv
module tb_conv1d_fetch;
  import conv1d_obi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, clear, ready;
  logic [31:0] src;
  logic [15:0] len;
  obi_req_t    obi_req;
  obi_resp_t   obi_rsp;
  logic [31:0] data_o;
  logic        valid_o, last_o, busy_o, done_o;

  // memory model controls
  logic        gnt_allow, rv_hold;
  int          rv_max;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic [31:0] pend[$];
  int          rv_wait;

  // monitor
  logic [31:0] gaddr[$];
  logic [31:0] sdata[$];
  logic        slast[$];
  int ndone, nbusy, nreq, nvalid, cyc, first_hs, last_hs, done_cyc;
  int total, bad;

  always #5 clk = ~clk;

  conv1d_fetch #(.Depth(4), .LenWidth(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .clear_i(clear),
    .src_addr_i(src), .len_i(len), .obi_req_o(obi_req), .obi_rsp_i(obi_rsp),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready), .last_o(last_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign gnt     = obi_req.req & gnt_allow;
  assign obi_rsp = {gnt, rvalid, rdata};

  always @(posedge clk) cyc <= cyc + 1;

  // OBI slave: in-order responses, rv_wait cycles of gap between them
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend.delete();
      rvalid  <= 1'b0;
      rdata   <= '0;
      rv_wait <= 0;
    end else begin
      if (obi_req.req && gnt) pend.push_back(obi_req.addr);
      rvalid <= 1'b0;
      if (rv_wait > 0) rv_wait <= rv_wait - 1;
      else if (pend.size() > 0 && !rv_hold) begin
        rvalid  <= 1'b1;
        rdata   <= mem_f(pend.pop_front());
        rv_wait <= $urandom_range(0, rv_max);
      end
    end
  end

  always @(negedge clk) if (rst_n) begin
    if (obi_req.req && gnt) gaddr.push_back(obi_req.addr);
    if (valid_o && ready) begin
      if (sdata.size() == 0) first_hs <= cyc;
      sdata.push_back(data_o);
      slast.push_back(last_o);
      last_hs <= cyc;
    end
    if (done_o) begin ndone <= ndone + 1; done_cyc <= cyc; end
    if (busy_o) nbusy <= nbusy + 1;
    if (obi_req.req) nreq <= nreq + 1;
    if (valid_o) nvalid <= nvalid + 1;
  end

  task automatic clr_mon();
    gaddr.delete(); sdata.delete(); slast.delete();
    ndone = 0; nbusy = 0; nreq = 0; nvalid = 0;
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    ok = 0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk); #1;
      if (!busy_o) begin ok = 1; break; end
    end
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    obi_req_t exp;
    exp = '0; exp.be = 4'hF;
    total++; if (obi_req !== exp) begin bad++; $display("FAIL reset_obi_req got=%h exp=%h", obi_req, exp); end
    total++; if (data_o !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", data_o); end
    total++; if ({valid_o, last_o, busy_o, done_o} !== 4'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=0000", {valid_o, last_o, busy_o, done_o}); end
  endtask

  task automatic test_basic();
    bit ok; logic [31:0] a, d;
    clr_mon();
    @(posedge clk); #1; src = 32'h1000; len = 16'd8; start = 1;
    @(posedge clk); #1; start = 0;
    total++; if (busy_o !== 1'b1 || obi_req.req !== 1'b1 || obi_req.addr !== 32'h1000) begin
      bad++; $display("FAIL basic_start busy=%b req=%b addr=%h exp busy=1 req=1 addr=00001000",
                      busy_o, obi_req.req, obi_req.addr); end
    wait_idle(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_timeout busy=%b exp=0", busy_o); end
    total++; if (gaddr.size() != 8) begin bad++; $display("FAIL basic_ngrant got=%0d exp=8", gaddr.size()); end
    total++; if (sdata.size() != 8) begin bad++; $display("FAIL basic_nword got=%0d exp=8", sdata.size()); end
    for (int i = 0; i < 8; i++) begin
      a = (i < gaddr.size()) ? gaddr[i] : 32'hx;
      d = (i < sdata.size()) ? sdata[i] : 32'hx;
      total++; if (a !== 32'h1000 + 32'(4*i)) begin bad++; $display("FAIL basic_addr[%0d] got=%h exp=%h", i, a, 32'h1000 + 32'(4*i)); end
      total++; if (d !== mem_f(32'h1000 + 32'(4*i))) begin bad++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, d, mem_f(32'h1000 + 32'(4*i))); end
      total++; if (i < slast.size() && slast[i] !== (i == 7)) begin bad++; $display("FAIL basic_last[%0d] got=%b exp=%b", i, slast[i], i == 7); end
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL basic_ndone got=%0d exp=1", ndone); end
    total++; if (done_cyc != last_hs + 1) begin bad++; $display("FAIL basic_done_lat got=%0d exp=%0d", done_cyc - last_hs, 1); end
    total++; if (last_hs - first_hs != 7) begin bad++; $display("FAIL basic_throughput span=%0d exp=7", last_hs - first_hs); end
  endtask

  task automatic test_backpressure();
    bit ok; logic [31:0] d;
    clr_mon();
    @(posedge clk); #1; ready = 0; src = 32'h1000; len = 16'd8; start = 1;
    @(posedge clk); #1; start = 0;
    repeat (20) @(posedge clk);
    #1;
    total++; if (gaddr.size() != 4) begin bad++; $display("FAIL bp_ngrant got=%0d exp=4", gaddr.size()); end
    total++; if (obi_req.req !== 1'b0) begin bad++; $display("FAIL bp_req got=%b exp=0", obi_req.req); end
    total++; if (valid_o !== 1'b1 || data_o !== mem_f(32'h1000)) begin
      bad++; $display("FAIL bp_head valid=%b data=%h exp valid=1 data=%h", valid_o, data_o, mem_f(32'h1000)); end
    ready = 1;
    wait_idle(200, ok);
    total++; if (!ok) begin bad++; $display("FAIL bp_timeout busy=%b exp=0", busy_o); end
    total++; if (sdata.size() != 8) begin bad++; $display("FAIL bp_nword got=%0d exp=8", sdata.size()); end
    for (int i = 0; i < 8; i++) begin
      d = (i < sdata.size()) ? sdata[i] : 32'hx;
      total++; if (d !== mem_f(32'h1000 + 32'(4*i))) begin bad++; $display("FAIL bp_data[%0d] got=%h exp=%h", i, d, mem_f(32'h1000 + 32'(4*i))); end
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL bp_ndone got=%0d exp=1", ndone); end
  endtask

  task automatic test_zero_len();
    clr_mon();
    @(posedge clk); #1; src = 32'h2000; len = 16'd0; start = 1;
    @(posedge clk); #1; start = 0;
    total++; if (done_o !== 1'b1 || busy_o !== 1'b0 || obi_req.req !== 1'b0) begin
      bad++; $display("FAIL zero_pulse done=%b busy=%b req=%b exp done=1 busy=0 req=0", done_o, busy_o, obi_req.req); end
    repeat (5) @(posedge clk);
    #1;
    total++; if (nreq != 0 || nbusy != 0) begin bad++; $display("FAIL zero_quiet nreq=%0d nbusy=%0d exp 0 0", nreq, nbusy); end
    total++; if (ndone != 1) begin bad++; $display("FAIL zero_ndone got=%0d exp=1", ndone); end
  endtask

  task automatic test_wrap();
    bit ok; logic [31:0] a, d;
    logic [31:0] exp_a [4];
    exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0; exp_a[3] = 32'h4;
    clr_mon();
    @(posedge clk); #1; src = 32'hFFFF_FFFB; len = 16'd4; start = 1;  // low bits ignored
    @(posedge clk); #1; start = 0;
    wait_idle(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL wrap_timeout busy=%b exp=0", busy_o); end
    for (int i = 0; i < 4; i++) begin
      a = (i < gaddr.size()) ? gaddr[i] : 32'hx;
      d = (i < sdata.size()) ? sdata[i] : 32'hx;
      total++; if (a !== exp_a[i]) begin bad++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, a, exp_a[i]); end
      total++; if (d !== mem_f(exp_a[i])) begin bad++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, d, mem_f(exp_a[i])); end
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL wrap_ndone got=%0d exp=1", ndone); end
  endtask

  task automatic test_abort();
    bit ok; logic [31:0] d;
    clr_mon();
    @(posedge clk); #1; ready = 0; rv_hold = 1; src = 32'h3000; len = 16'd8; start = 1;
    @(posedge clk); #1; start = 0;          // grants in this and the next two cycles
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1; gnt_allow = 0; rv_hold = 0;
    @(posedge clk); #1; rv_hold = 1;        // exactly one response returned
    @(posedge clk); #1;
    total++; if (gaddr.size() != 3 || valid_o !== 1'b1) begin
      bad++; $display("FAIL abort_setup ngrant=%0d valid=%b exp 3 1", gaddr.size(), valid_o); end
    clear = 1;
    #1;
    total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL abort_valid_drop got=%b exp=0", valid_o); end
    @(posedge clk); #1; clear = 0; gnt_allow = 1; rv_hold = 0;
    clr_mon();
    total++; if (busy_o !== 1'b1 || obi_req.req !== 1'b0) begin
      bad++; $display("FAIL abort_flush busy=%b req=%b exp 1 0", busy_o, obi_req.req); end
    wait_idle(50, ok);
    total++; if (!ok) begin bad++; $display("FAIL abort_timeout busy=%b exp=0", busy_o); end
    total++; if (nvalid != 0 || ndone != 0 || nreq != 0) begin
      bad++; $display("FAIL abort_quiet nvalid=%0d ndone=%0d nreq=%0d exp 0 0 0", nvalid, ndone, nreq); end
    ready = 1;
    clr_mon();
    @(posedge clk); #1; src = 32'h4000; len = 16'd2; start = 1;
    @(posedge clk); #1; start = 0;
    wait_idle(100, ok);
    total++; if (!ok) begin bad++; $display("FAIL abort_restart_timeout busy=%b exp=0", busy_o); end
    for (int i = 0; i < 2; i++) begin
      d = (i < sdata.size()) ? sdata[i] : 32'hx;
      total++; if (d !== mem_f(32'h4000 + 32'(4*i))) begin bad++; $display("FAIL abort_restart_data[%0d] got=%h exp=%h", i, d, mem_f(32'h4000 + 32'(4*i))); end
    end
    total++; if (sdata.size() != 2 || ndone != 1 || slast.size() != 2 || slast[1] !== 1'b1) begin
      bad++; $display("FAIL abort_restart_end nword=%0d ndone=%0d exp 2 1 with last on word 2", sdata.size(), ndone); end
  endtask

  task automatic run_stress(input logic [31:0] s, input int n);
    bit ok; logic [31:0] d;
    clr_mon();
    rv_max = 5;
    @(posedge clk); #1; src = s; len = 16'(n); start = 1;
    @(posedge clk); #1; start = 0;
    ok = 0;
    for (int k = 0; k < 3000; k++) begin
      gnt_allow = ($urandom_range(0, 2) != 0);
      ready     = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
      if (!busy_o) begin ok = 1; break; end
    end
    @(negedge clk); #1;
    gnt_allow = 1; ready = 1; rv_max = 0;
    total++; if (!ok) begin bad++; $display("FAIL stress_timeout src=%h busy=%b exp=0", s, busy_o); end
    total++; if (sdata.size() != n) begin bad++; $display("FAIL stress_nword got=%0d exp=%0d", sdata.size(), n); end
    for (int i = 0; i < n; i++) begin
      d = (i < sdata.size()) ? sdata[i] : 32'hx;
      total++; if (d !== mem_f(s + 32'(4*i))) begin bad++; $display("FAIL stress_data[%0d] got=%h exp=%h", i, d, mem_f(s + 32'(4*i))); end
      total++; if (i < slast.size() && slast[i] !== (i == n-1)) begin bad++; $display("FAIL stress_last[%0d] got=%b exp=%b", i, slast[i], i == n-1); end
    end
    total++; if (ndone != 1) begin bad++; $display("FAIL stress_ndone got=%0d exp=1", ndone); end
  endtask

  task automatic test_stress();
    run_stress(32'h5000, 13);
    run_stress(32'h6000, 7);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst_n = 0; start = 0; clear = 0; src = '0; len = '0; ready = 1;
    gnt_allow = 1; rv_hold = 0; rv_max = 0;
    ndone = 0; nbusy = 0; nreq = 0; nvalid = 0; first_hs = 0; last_hs = 0; done_cyc = 0;
    @(posedge clk); #1;
    test_reset();
    @(posedge clk); #1; rst_n = 1;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_wrap();
    test_abort();
    test_stress();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
